// File: rtl/ls_queue_pkg.sv
// rtl/ls_queue_pkg.sv - shared load/store queue encodings and FSM states
package ls_queue_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;

    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    // addr[17:16] value that selects the uncached I/O window
    localparam logic [1:0] IO_REGION = 2'b11;

    // operand tag MSB value meaning "still waiting on a ROB result"
    localparam logic TAG_WAIT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_MEM,
        ST_FAULT
    } lsq_state_e;

    function automatic logic tag_ready(input logic tag_msb);
        return tag_msb != TAG_WAIT;
    endfunction

endpackage

// File: rtl/ls_align.sv
// rtl/ls_align.sv - access length, misalignment check and load extension
module ls_align
    import ls_queue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [2:0]      len,
    output logic            misaligned,
    output logic [XLEN-1:0] ext_data
);

    always_comb begin
        len        = LEN_W;
        misaligned = 1'b0;
        ext_data   = rdata;
        case (funct3[1:0])
            SIZE_B: begin
                len      = LEN_B;
                ext_data = funct3[2] ? {{(XLEN-8){1'b0}}, rdata[7:0]}
                                     : {{(XLEN-8){rdata[7]}}, rdata[7:0]};
            end
            SIZE_H: begin
                len        = LEN_H;
                misaligned = addr_lo[0];
                ext_data   = funct3[2] ? {{(XLEN-16){1'b0}}, rdata[15:0]}
                                       : {{(XLEN-16){rdata[15]}}, rdata[15:0]};
            end
            default: begin
                len        = LEN_W;
                misaligned = addr_lo != 2'b00;
            end
        endcase
    end

endmodule

// File: rtl/ls_queue.sv
// rtl/ls_queue.sv - in-order load/store queue with CDB snooping and flush recovery
module ls_queue
    import ls_queue_pkg::*;
#(
    parameter int DEPTH_LOG = 4,
    parameter int ROB_W     = 4,
    parameter int XLEN      = 32,
    parameter int CDB_N     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flush,
    output logic                  nxt_full,
    output logic [DEPTH_LOG:0]    occupancy,
    input  logic                  issue,
    input  logic [ROB_W-1:0]      issue_rob,
    input  logic                  issue_store,
    input  logic [2:0]            issue_funct3,
    input  logic [ROB_W:0]        issue_rs1_tag,
    input  logic [XLEN-1:0]       issue_rs1_val,
    input  logic [ROB_W:0]        issue_rs2_tag,
    input  logic [XLEN-1:0]       issue_rs2_val,
    input  logic [XLEN-1:0]       issue_imm,
    input  logic [CDB_N-1:0]      cdb_valid,
    input  logic [CDB_N*ROB_W-1:0] cdb_rob,
    input  logic [CDB_N*XLEN-1:0] cdb_val,
    input  logic                  commit_store,
    input  logic [ROB_W-1:0]      commit_rob,
    input  logic [ROB_W-1:0]      head_rob,
    output logic                  mc_en,
    output logic                  mc_wr,
    output logic [XLEN-1:0]       mc_addr,
    output logic [2:0]            mc_len,
    output logic [XLEN-1:0]       mc_wdata,
    input  logic                  mc_done,
    input  logic [XLEN-1:0]       mc_rdata,
    output logic                  res_valid,
    output logic [ROB_W-1:0]      res_rob,
    output logic [XLEN-1:0]       res_val,
    output logic                  res_exc
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam int BC_N  = CDB_N + 1;
    localparam logic [DEPTH_LOG-1:0] ONE_PTR  = 1;
    localparam logic [DEPTH_LOG:0]   ONE_CNT  = 1;
    localparam logic [DEPTH_LOG:0]   FULL_CNT = {1'b1, {DEPTH_LOG{1'b0}}};

    logic [DEPTH-1:0] busy, committed, e_store;
    logic [ROB_W-1:0] e_rob     [DEPTH];
    logic [2:0]       e_funct3  [DEPTH];
    logic [ROB_W:0]   e_rs1_tag [DEPTH];
    logic [ROB_W:0]   e_rs2_tag [DEPTH];
    logic [XLEN-1:0]  e_rs1_val [DEPTH];
    logic [XLEN-1:0]  e_rs2_val [DEPTH];
    logic [XLEN-1:0]  e_imm     [DEPTH];

    logic [DEPTH_LOG-1:0] head, tail, head_nx, yc_ptr, keep_span, commit_idx;
    logic                 yc_valid, pop_yc, flush_keep, commit_hit, issue_ok;
    logic [DEPTH_LOG:0]   occ_nxt, keep_cnt;

    lsq_state_e state, state_nxt;
    logic       start, pop, fault_evt;

    logic [XLEN-1:0] h_addr, ld_ext;
    logic [2:0]      h_len;
    logic            h_mis, h_ready, h_io, h_start_ld, h_start_st, h_fault;

    // Every snooped broadcast source, with our own result as the last channel
    logic [BC_N-1:0]            bc_valid;
    logic [BC_N-1:0][ROB_W-1:0] bc_rob;
    logic [BC_N-1:0][XLEN-1:0]  bc_val;
    logic [XLEN:0]              w1 [DEPTH];
    logic [XLEN:0]              w2 [DEPTH];
    logic [XLEN:0]              is1, is2;

    function automatic logic [XLEN:0] snoop(
        input logic [ROB_W:0]               tag,
        input logic [BC_N-1:0]              v,
        input logic [BC_N-1:0][ROB_W-1:0]   r,
        input logic [BC_N-1:0][XLEN-1:0]    d
    );
        logic [XLEN:0] hit;
        hit = '0;
        for (int c = 0; c < BC_N; c++) begin
            if (v[c] && !tag_ready(tag[ROB_W]) && tag[ROB_W-1:0] == r[c]) begin
                hit = {1'b1, d[c]};
            end
        end
        return hit;
    endfunction

    always_comb begin
        bc_valid = '0;
        bc_rob   = '0;
        bc_val   = '0;
        for (int c = 0; c < CDB_N; c++) begin
            bc_valid[c] = cdb_valid[c];
            bc_rob[c]   = cdb_rob[c*ROB_W +: ROB_W];
            bc_val[c]   = cdb_val[c*XLEN +: XLEN];
        end
        bc_valid[CDB_N] = res_valid;
        bc_rob[CDB_N]   = res_rob;
        bc_val[CDB_N]   = res_val;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w1[i] = snoop(e_rs1_tag[i], bc_valid, bc_rob, bc_val);
            w2[i] = snoop(e_rs2_tag[i], bc_valid, bc_rob, bc_val);
        end
        is1 = snoop(issue_rs1_tag, bc_valid, bc_rob, bc_val);
        is2 = snoop(issue_rs2_tag, bc_valid, bc_rob, bc_val);
    end

    assign h_addr = e_rs1_val[head] + e_imm[head];

    ls_align #(.XLEN(XLEN)) u_align (
        .funct3     (e_funct3[head]),
        .addr_lo    (h_addr[1:0]),
        .rdata      (mc_rdata),
        .len        (h_len),
        .misaligned (h_mis),
        .ext_data   (ld_ext)
    );

    assign h_ready    = busy[head] && tag_ready(e_rs1_tag[head][ROB_W])
                                   && tag_ready(e_rs2_tag[head][ROB_W]);
    assign h_io       = h_addr[17:16] == IO_REGION;
    assign h_start_ld = h_ready && !h_mis && !e_store[head] && !flush
                        && (!h_io || e_rob[head] == head_rob);
    assign h_start_st = h_ready && !h_mis && e_store[head] && committed[head];
    assign h_fault    = h_ready && h_mis && !flush;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        pop       = 1'b0;
        fault_evt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (h_fault) begin
                    state_nxt = ST_FAULT;
                    fault_evt = 1'b1;
                end else if (h_start_ld || h_start_st) begin
                    state_nxt = ST_WAIT_MEM;
                    start     = 1'b1;
                end
            end
            ST_WAIT_MEM: begin
                if (mc_done) begin
                    state_nxt = ST_IDLE;
                    pop       = 1'b1;
                end else if (flush && !committed[head]) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (flush) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else if (rdy) state <= state_nxt;
    end

    assign mc_en = state == ST_WAIT_MEM;

    always_ff @(posedge clk) begin
        if (rst) begin
            mc_wr    <= 1'b0;
            mc_addr  <= '0;
            mc_len   <= '0;
            mc_wdata <= '0;
        end else if (rdy && start) begin
            mc_wr    <= e_store[head];
            mc_addr  <= h_addr;
            mc_len   <= h_len;
            mc_wdata <= e_rs2_val[head];
        end
    end

    always_comb begin
        commit_hit = 1'b0;
        commit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (busy[i] && !committed[i] && e_store[i] && e_rob[i] == commit_rob) begin
                commit_hit = commit_store && !flush;
                commit_idx = DEPTH_LOG'(i);
            end
        end
    end

    // Committed stores always form a prefix from head, so flush keeps head..yc_ptr
    assign issue_ok   = issue && !flush;
    assign head_nx    = pop ? head + ONE_PTR : head;
    assign pop_yc     = pop && head == yc_ptr;
    assign flush_keep = yc_valid && !pop_yc;
    assign keep_span  = yc_ptr - head_nx;
    assign keep_cnt   = {1'b0, keep_span} + ONE_CNT;

    always_comb begin
        occ_nxt = occupancy;
        if (rst) begin
            occ_nxt = '0;
        end else if (rdy) begin
            if (flush) occ_nxt = flush_keep ? keep_cnt : '0;
            else occ_nxt = occupancy + (issue_ok ? ONE_CNT : '0) - (pop ? ONE_CNT : '0);
        end
    end

    assign nxt_full = occ_nxt == FULL_CNT;

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
            yc_ptr    <= '0;
            yc_valid  <= 1'b0;
        end else if (rdy) begin
            occupancy <= occ_nxt;
            head      <= head_nx;
            if (flush) begin
                if (flush_keep) begin
                    tail <= yc_ptr + ONE_PTR;
                end else begin
                    tail     <= head_nx;
                    yc_valid <= 1'b0;
                end
            end else begin
                if (issue_ok) tail <= tail + ONE_PTR;
                if (commit_hit) begin
                    yc_ptr   <= commit_idx;
                    yc_valid <= 1'b1;
                end else if (pop_yc) begin
                    yc_valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= '0;
            committed <= '0;
        end else if (rdy) begin
            if (pop) begin
                busy[head]      <= 1'b0;
                committed[head] <= 1'b0;
            end
            if (flush) begin
                busy <= busy & committed & ~(pop ? (DEPTH'(1) << head) : '0);
            end else begin
                if (commit_hit) committed[commit_idx] <= 1'b1;
                // issue into the slot being popped at full must win
                if (issue_ok) begin
                    busy[tail]      <= 1'b1;
                    committed[tail] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w1[i][XLEN]) begin
                    e_rs1_tag[i] <= {~TAG_WAIT, e_rs1_tag[i][ROB_W-1:0]};
                    e_rs1_val[i] <= w1[i][XLEN-1:0];
                end
                if (w2[i][XLEN]) begin
                    e_rs2_tag[i] <= {~TAG_WAIT, e_rs2_tag[i][ROB_W-1:0]};
                    e_rs2_val[i] <= w2[i][XLEN-1:0];
                end
            end
            if (issue_ok) begin
                e_rob[tail]     <= issue_rob;
                e_store[tail]   <= issue_store;
                e_funct3[tail]  <= issue_funct3;
                e_imm[tail]     <= issue_imm;
                e_rs1_tag[tail] <= is1[XLEN] ? {~TAG_WAIT, issue_rs1_tag[ROB_W-1:0]} : issue_rs1_tag;
                e_rs1_val[tail] <= is1[XLEN] ? is1[XLEN-1:0] : issue_rs1_val;
                e_rs2_tag[tail] <= is2[XLEN] ? {~TAG_WAIT, issue_rs2_tag[ROB_W-1:0]} : issue_rs2_tag;
                e_rs2_val[tail] <= is2[XLEN] ? is2[XLEN-1:0] : issue_rs2_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_exc   <= 1'b0;
            res_rob   <= '0;
            res_val   <= '0;
        end else if (rdy) begin
            res_valid <= 1'b0;
            res_exc   <= 1'b0;
            if (pop && !e_store[head] && !flush) begin
                res_valid <= 1'b1;
                res_rob   <= e_rob[head];
                res_val   <= ld_ext;
            end else if (fault_evt) begin
                res_valid <= 1'b1;
                res_exc   <= 1'b1;
                res_rob   <= e_rob[head];
                res_val   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ls_queue.sv
// tb/tb_ls_queue.sv - directed self-checking bench for ls_queue
module tb_ls_queue;
    import ls_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, nxt_full;
    logic [4:0]  occupancy;
    logic        issue, issue_store;
    logic [3:0]  issue_rob;
    logic [2:0]  issue_funct3;
    logic [4:0]  issue_rs1_tag, issue_rs2_tag;
    logic [31:0] issue_rs1_val, issue_rs2_val, issue_imm;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_rob;
    logic [63:0] cdb_val;
    logic        commit_store;
    logic [3:0]  commit_rob, head_rob;
    logic        mc_en, mc_wr, mc_done;
    logic [31:0] mc_addr, mc_wdata, mc_rdata;
    logic [2:0]  mc_len;
    logic        res_valid, res_exc;
    logic [3:0]  res_rob;
    logic [31:0] res_val;

    int errors = 0;
    int checks = 0;

    logic [2:0]  a_f3  [5] = '{F3_LB, F3_LBU, F3_LH, F3_LHU, F3_LW};
    logic [31:0] a_rd  [5] = '{32'h80, 32'h80, 32'h8001, 32'h8001, 32'h80};
    logic [31:0] a_exp [5] = '{32'hFFFFFF80, 32'h80, 32'hFFFF8001, 32'h8001, 32'h80};
    logic [2:0]  a_len [5] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd4};

    ls_queue dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .nxt_full(nxt_full), .occupancy(occupancy),
        .issue(issue), .issue_rob(issue_rob), .issue_store(issue_store),
        .issue_funct3(issue_funct3), .issue_rs1_tag(issue_rs1_tag),
        .issue_rs1_val(issue_rs1_val), .issue_rs2_tag(issue_rs2_tag),
        .issue_rs2_val(issue_rs2_val), .issue_imm(issue_imm),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_val(cdb_val),
        .commit_store(commit_store), .commit_rob(commit_rob), .head_rob(head_rob),
        .mc_en(mc_en), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_len(mc_len),
        .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata),
        .res_valid(res_valid), .res_rob(res_rob), .res_val(res_val), .res_exc(res_exc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_issue(input logic [3:0] rob, input logic st, input logic [2:0] f3,
                             input logic [4:0] t1, input logic [31:0] v1,
                             input logic [4:0] t2, input logic [31:0] v2,
                             input logic [31:0] imm);
        issue = 1'b1; issue_rob = rob; issue_store = st; issue_funct3 = f3;
        issue_rs1_tag = t1; issue_rs1_val = v1; issue_rs2_tag = t2; issue_rs2_val = v2;
        issue_imm = imm;
    endtask

    task automatic issue_one(input logic [3:0] rob, input logic st, input logic [2:0] f3,
                             input logic [31:0] v1, input logic [31:0] imm);
        set_issue(rob, st, f3, 5'd0, v1, 5'd0, 32'h55, imm);
        step();
        issue = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; issue = 1'b0; issue_rob = '0;
        issue_store = 1'b0; issue_funct3 = '0; issue_rs1_tag = '0; issue_rs2_tag = '0;
        issue_rs1_val = '0; issue_rs2_val = '0; issue_imm = '0;
        cdb_valid = '0; cdb_rob = '0; cdb_val = '0; commit_store = 1'b0;
        commit_rob = '0; head_rob = '0; mc_done = 1'b0; mc_rdata = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_nxt_full", 32'(nxt_full), 0);
        chk("rst_mc_en", 32'(mc_en), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_exc", 32'(res_exc), 0);

        // load width/extension table, addr 0x100+4
        for (int i = 0; i < 5; i++) begin
            issue_one(4'(i + 1), 1'b0, a_f3[i], 32'h100, 32'h4);
            chk("ld_occ", 32'(occupancy), 1);
            chk("ld_mc_en_pre", 32'(mc_en), 0);
            step();
            chk("ld_mc_en", 32'(mc_en), 1);
            chk("ld_mc_addr", mc_addr, 32'h104);
            chk("ld_mc_len", 32'(mc_len), 32'(a_len[i]));
            chk("ld_mc_wr", 32'(mc_wr), 0);
            mc_done = 1'b1; mc_rdata = a_rd[i];
            step();
            mc_done = 1'b0;
            chk("ld_res_valid", 32'(res_valid), 1);
            chk("ld_res_val", res_val, a_exp[i]);
            chk("ld_res_rob", 32'(res_rob), i + 1);
            chk("ld_mc_en_post", 32'(mc_en), 0);
            step();
            chk("ld_res_pulse", 32'(res_valid), 0);
        end

        // fill to full with uncommitted stores
        for (int i = 0; i < 16; i++) begin
            set_issue(4'(i), 1'b1, F3_SW, 5'd0, 32'h200, 5'd0, 32'(i), 32'h0);
            #1;
            if (i == 14) chk("fill_nxt_full_14", 32'(nxt_full), 0);
            if (i == 15) chk("fill_nxt_full_15", 32'(nxt_full), 1);
            step();
        end
        issue = 1'b0;
        chk("full_occ", 32'(occupancy), 16);
        chk("full_mc_en", 32'(mc_en), 0);
        commit_store = 1'b1; commit_rob = 4'd0;
        step();
        commit_store = 1'b0;
        step();
        chk("full_st_mc_en", 32'(mc_en), 1);
        chk("full_st_mc_wr", 32'(mc_wr), 1);
        mc_done = 1'b1;
        set_issue(4'd0, 1'b1, F3_SW, 5'd0, 32'h200, 5'd0, 32'h0, 32'h0);
        #1;
        chk("full_swap_nxt_full", 32'(nxt_full), 1);
        step();
        mc_done = 1'b0; issue = 1'b0;
        chk("full_swap_occ", 32'(occupancy), 16);
        chk("st_no_result", 32'(res_valid), 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_all_occ", 32'(occupancy), 0);
        chk("flush_all_nxt_full", 32'(nxt_full), 0);

        // store data arrives on cdb channel 1
        set_issue(4'd5, 1'b1, F3_SW, 5'd0, 32'h200, 5'b1_0011, 32'h0, 32'h0);
        step();
        issue = 1'b0;
        cdb_valid = 2'b10; cdb_rob = {4'd3, 4'd0}; cdb_val = {32'hDEAD, 32'h0};
        step();
        cdb_valid = '0;
        step();
        chk("st_wait_commit", 32'(mc_en), 0);
        commit_store = 1'b1; commit_rob = 4'd5;
        step();
        commit_store = 1'b0;
        step();
        chk("cdb_st_mc_en", 32'(mc_en), 1);
        chk("cdb_st_mc_wr", 32'(mc_wr), 1);
        chk("cdb_st_wdata", mc_wdata, 32'hDEAD);
        step();
        chk("cdb_st_hold_en", 32'(mc_en), 1);
        chk("cdb_st_hold_wdata", mc_wdata, 32'hDEAD);
        chk("cdb_st_hold_addr", mc_addr, 32'h200);
        mc_done = 1'b1;
        step();
        mc_done = 1'b0;
        chk("cdb_st_done_occ", 32'(occupancy), 0);
        chk("cdb_st_no_res", 32'(res_valid), 0);

        // issue-cycle bypass on cdb channel 0
        set_issue(4'd6, 1'b1, F3_SW, 5'd0, 32'h200, 5'b1_0111, 32'h0, 32'h0);
        cdb_valid = 2'b01; cdb_rob = {4'd0, 4'd7}; cdb_val = {32'h0, 32'hBEEF};
        step();
        issue = 1'b0; cdb_valid = '0;
        commit_store = 1'b1; commit_rob = 4'd6;
        step();
        commit_store = 1'b0;
        step();
        chk("byp_wdata", mc_wdata, 32'hBEEF);
        mc_done = 1'b1;
        step();
        mc_done = 1'b0;

        // I/O load waits for ROB head
        head_rob = 4'd2;
        issue_one(4'd9, 1'b0, F3_LW, 32'h30000, 32'h0);
        step(); step(); step();
        chk("io_blocked", 32'(mc_en), 0);
        head_rob = 4'd9;
        step();
        chk("io_go", 32'(mc_en), 1);
        chk("io_addr", mc_addr, 32'h30000);
        mc_done = 1'b1; mc_rdata = 32'h1234;
        step();
        mc_done = 1'b0; head_rob = 4'd0;
        chk("io_res_val", res_val, 32'h1234);
        chk("io_res_rob", 32'(res_rob), 9);

        // misaligned halfword
        issue_one(4'd4, 1'b0, F3_LH, 32'h100, 32'h1);
        chk("mis_pre", 32'(res_valid), 0);
        step();
        chk("mis_res_valid", 32'(res_valid), 1);
        chk("mis_res_exc", 32'(res_exc), 1);
        chk("mis_res_rob", 32'(res_rob), 4);
        chk("mis_mc_en", 32'(mc_en), 0);
        step();
        chk("mis_pulse", 32'(res_valid), 0);
        chk("mis_stall_occ", 32'(occupancy), 1);
        chk("mis_stall_en", 32'(mc_en), 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("mis_flush_occ", 32'(occupancy), 0);
        issue_one(4'd10, 1'b0, F3_LW, 32'h40, 32'h0);
        step();
        chk("mis_idle_again", 32'(mc_en), 1);
        mc_done = 1'b1;
        step();
        mc_done = 1'b0;

        // flush keeps the committed store in flight, drops younger loads
        set_issue(4'd11, 1'b1, F3_SW, 5'd0, 32'h300, 5'd0, 32'h55, 32'h0);
        step();
        issue_one(4'd12, 1'b0, F3_LW, 32'h304, 32'h0);
        issue_one(4'd13, 1'b0, F3_LW, 32'h304, 32'h0);
        chk("keep_occ3", 32'(occupancy), 3);
        commit_store = 1'b1; commit_rob = 4'd11;
        step();
        commit_store = 1'b0;
        step();
        chk("keep_mc_en", 32'(mc_en), 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("keep_cont_en", 32'(mc_en), 1);
        chk("keep_occ1", 32'(occupancy), 1);
        mc_done = 1'b1;
        step();
        mc_done = 1'b0;
        chk("keep_done_occ", 32'(occupancy), 0);
        step();
        chk("keep_loads_gone", 32'(mc_en), 0);

        // flush beats a same-cycle commit
        issue_one(4'd14, 1'b1, F3_SW, 32'h200, 32'h0);
        flush = 1'b1; commit_store = 1'b1; commit_rob = 4'd14;
        step();
        flush = 1'b0; commit_store = 1'b0;
        chk("flush_commit_occ", 32'(occupancy), 0);
        step();
        chk("flush_commit_en", 32'(mc_en), 0);

        // load completing in a flush cycle is dropped silently
        issue_one(4'd15, 1'b0, F3_LW, 32'h40, 32'h0);
        step();
        chk("sup_mc_en", 32'(mc_en), 1);
        mc_done = 1'b1; flush = 1'b1; mc_rdata = 32'h77;
        step();
        mc_done = 1'b0; flush = 1'b0;
        chk("sup_res_valid", 32'(res_valid), 0);
        chk("sup_occ", 32'(occupancy), 0);
        chk("sup_mc_en_post", 32'(mc_en), 0);

        // rdy low freezes everything
        rdy = 1'b0;
        issue_one(4'd1, 1'b0, F3_LW, 32'h40, 32'h0);
        rdy = 1'b1;
        chk("rdy_freeze_occ", 32'(occupancy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
